// File: rtl/seg_monitor.sv
// Receive-side checker for the countdown display. It decodes both 7-segment digits and the light code,
// and flags any sampled tick that is not a legal decrement, hold, or reload at a light change.
module seg_monitor #(
   parameter int ERR_W      = 8,
   parameter bit CHECK_HOLD = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             en,
   input  logic [6:0]       high_seg,
   input  logic [6:0]       low_seg,
   input  logic [1:0]       light,
   input  logic             clr_err,
   output logic [3:0]       bcd_hi,
   output logic [3:0]       bcd_lo,
   output logic             dec_valid,
   output logic             err,
   output logic [2:0]       err_code,
   output logic [ERR_W-1:0] err_cnt,
   output logic             dbg_state
);

   typedef enum logic {IDLE = 1'b0, TRACK = 1'b1} state_t;

   localparam logic [2:0] E_NONE     = 3'd0;
   localparam logic [2:0] E_BADSEG   = 3'd1;
   localparam logic [2:0] E_BADLIGHT = 3'd2;
   localparam logic [2:0] E_LIGHTCHG = 3'd3;
   localparam logic [2:0] E_RELOAD0  = 3'd4;
   localparam logic [2:0] E_HOLD     = 3'd5;
   localparam logic [2:0] E_STEP     = 3'd6;

   // Returns {valid, digit}; an unknown pattern decodes to digit 4'hF with valid low.
   function automatic logic [4:0] seg_dec(input logic [6:0] s);
      case (s)
         7'h7E:   seg_dec = {1'b1, 4'd0};
         7'h30:   seg_dec = {1'b1, 4'd1};
         7'h6D:   seg_dec = {1'b1, 4'd2};
         7'h79:   seg_dec = {1'b1, 4'd3};
         7'h33:   seg_dec = {1'b1, 4'd4};
         7'h5B:   seg_dec = {1'b1, 4'd5};
         7'h5F:   seg_dec = {1'b1, 4'd6};
         7'h70:   seg_dec = {1'b1, 4'd7};
         7'h7F:   seg_dec = {1'b1, 4'd8};
         7'h7B:   seg_dec = {1'b1, 4'd9};
         default: seg_dec = {1'b0, 4'hF};
      endcase
   endfunction

   state_t           state_q, state_d;
   logic [7:0]       prev_val_q, prev_val_d;
   logic [1:0]       prev_light_q, prev_light_d;
   logic [3:0]       bcd_hi_q, bcd_hi_d, bcd_lo_q, bcd_lo_d;
   logic             dec_valid_q, dec_valid_d;
   logic             err_q, err_d;
   logic [2:0]       err_code_q, err_code_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   logic [4:0]       hi_dec, lo_dec;
   logic             samp_ok, light_chg, prev_zero;
   logic [7:0]       samp_val, step_val;
   logic [2:0]       code;

   always_comb begin
      hi_dec    = seg_dec(high_seg);
      lo_dec    = seg_dec(low_seg);
      samp_ok   = hi_dec[4] & lo_dec[4];
      samp_val  = {hi_dec[3:0], lo_dec[3:0]};
      light_chg = (light != prev_light_q);
      prev_zero = (prev_val_q == 8'h00);
      // BCD decrement with borrow; meaningless for prev 00, which is excluded separately.
      step_val  = (prev_val_q[3:0] == 4'd0) ? {prev_val_q[7:4] - 4'd1, 4'd9}
                                            : {prev_val_q[7:4], prev_val_q[3:0] - 4'd1};

      code = E_NONE;
      if (!samp_ok) begin
         code = E_BADSEG;
      end else if (light == 2'b11) begin
         code = E_BADLIGHT;
      end else if (state_q == TRACK) begin
         if (light_chg && !prev_zero) begin
            code = E_LIGHTCHG;
         end else if (light_chg && (samp_val == 8'h00)) begin
            code = E_RELOAD0;
         end else if (!light_chg && !en && CHECK_HOLD && (samp_val != prev_val_q)) begin
            code = E_HOLD;
         end else if (!light_chg && en && (prev_zero || (samp_val != step_val))) begin
            code = E_STEP;
         end
      end

      state_d      = state_q;
      prev_val_d   = prev_val_q;
      prev_light_d = prev_light_q;
      bcd_hi_d     = bcd_hi_q;
      bcd_lo_d     = bcd_lo_q;
      dec_valid_d  = dec_valid_q;
      err_d        = err_q;
      err_code_d   = err_code_q;
      err_cnt_d    = err_cnt_q;

      if (tick) begin
         bcd_hi_d     = hi_dec[3:0];
         bcd_lo_d     = lo_dec[3:0];
         dec_valid_d  = (code != E_BADSEG);
         prev_val_d   = samp_val;
         prev_light_d = light;
         state_d      = ((code == E_BADSEG) || (code == E_BADLIGHT)) ? IDLE : TRACK;
         if (code != E_NONE) begin
            err_d      = 1'b1;
            err_code_d = code;
            err_cnt_d  = (err_cnt_q == {ERR_W{1'b1}}) ? err_cnt_q : err_cnt_q + ERR_W'(1);
         end
      end

      // Clear beats a coincident error, but the sample itself is still shown and seeds prev.
      if (clr_err) begin
         state_d    = IDLE;
         err_d      = 1'b0;
         err_code_d = E_NONE;
         err_cnt_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         prev_val_q   <= 8'h00;
         prev_light_q <= 2'b00;
         bcd_hi_q     <= 4'd0;
         bcd_lo_q     <= 4'd0;
         dec_valid_q  <= 1'b0;
         err_q        <= 1'b0;
         err_code_q   <= E_NONE;
         err_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         prev_val_q   <= prev_val_d;
         prev_light_q <= prev_light_d;
         bcd_hi_q     <= bcd_hi_d;
         bcd_lo_q     <= bcd_lo_d;
         dec_valid_q  <= dec_valid_d;
         err_q        <= err_d;
         err_code_q   <= err_code_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign bcd_hi    = bcd_hi_q;
   assign bcd_lo    = bcd_lo_q;
   assign dec_valid = dec_valid_q;
   assign err       = err_q;
   assign err_code  = err_code_q;
   assign err_cnt   = err_cnt_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_seg_monitor.sv
// Bench for seg_monitor: two instances (hold check on and off) share stimulus and are compared
// every cycle against a digit-level countdown model, with literal checks at the key scenario points.
module tb_seg_monitor;
   localparam int ERR_W = 8;

   logic clk = 1'b0, rst = 1'b1, tick = 1'b0, en = 1'b0, clr_err = 1'b0;
   logic [6:0] high_seg = 7'h7E, low_seg = 7'h7E;
   logic [1:0] light = 2'b00;

   logic [3:0]       o_hi  [2];
   logic [3:0]       o_lo  [2];
   logic             o_dv  [2];
   logic             o_err [2];
   logic [2:0]       o_code[2];
   logic [ERR_W-1:0] o_cnt [2];
   logic             o_st  [2];

   int n_assert = 0, n_fail = 0;
   bit cmp_on = 1'b0;

   logic [6:0] seg_tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

   always #5 clk = ~clk;

   seg_monitor #(.ERR_W(ERR_W), .CHECK_HOLD(1'b1)) dut (
      .clk(clk), .rst(rst), .tick(tick), .en(en), .high_seg(high_seg), .low_seg(low_seg),
      .light(light), .clr_err(clr_err), .bcd_hi(o_hi[0]), .bcd_lo(o_lo[0]), .dec_valid(o_dv[0]),
      .err(o_err[0]), .err_code(o_code[0]), .err_cnt(o_cnt[0]), .dbg_state(o_st[0]));

   seg_monitor #(.ERR_W(ERR_W), .CHECK_HOLD(1'b0)) dut_nh (
      .clk(clk), .rst(rst), .tick(tick), .en(en), .high_seg(high_seg), .low_seg(low_seg),
      .light(light), .clr_err(clr_err), .bcd_hi(o_hi[1]), .bcd_lo(o_lo[1]), .dec_valid(o_dv[1]),
      .err(o_err[1]), .err_code(o_code[1]), .err_cnt(o_cnt[1]), .dbg_state(o_st[1]));

   // ---------------- reference model (integer countdown value, not BCD registers) ----------------
   int m_track[2], m_prev[2], m_plight[2];
   int e_hi[2], e_lo[2], e_dv[2], e_err[2], e_code[2], e_cnt[2];

   function automatic int seg_to_dig(input logic [6:0] s);
      for (int i = 0; i < 10; i++) if (seg_tab[i] == s) return i;
      return -1;
   endfunction

   task automatic model_reset(input int k);
      m_track[k] = 0; m_prev[k] = 0; m_plight[k] = 0;
      e_hi[k] = 0; e_lo[k] = 0; e_dv[k] = 0; e_err[k] = 0; e_code[k] = 0; e_cnt[k] = 0;
   endtask

   task automatic model_step(input int k, input bit ch);
      int dh, dl, v, code;
      if (tick) begin
         dh = seg_to_dig(high_seg);
         dl = seg_to_dig(low_seg);
         v = dh * 10 + dl;
         code = 0;
         if (dh < 0 || dl < 0) code = 1;
         else if (light == 2'b11) code = 2;
         else if (m_track[k] != 0) begin
            if (int'(light) != m_plight[k]) begin
               if (m_prev[k] != 0) code = 3;
               else if (v == 0) code = 4;
            end else if (!en) begin
               if (ch && v != m_prev[k]) code = 5;
            end else if (v != m_prev[k] - 1) code = 6;
         end
         e_hi[k] = (dh < 0) ? 15 : dh;
         e_lo[k] = (dl < 0) ? 15 : dl;
         e_dv[k] = (code != 1);
         m_prev[k] = v;
         m_plight[k] = int'(light);
         m_track[k] = (code == 0 || code > 2);
         if (code != 0) begin
            e_err[k] = 1;
            e_code[k] = code;
            if (e_cnt[k] < 255) e_cnt[k]++;
         end
      end
      if (clr_err) begin
         m_track[k] = 0; e_err[k] = 0; e_code[k] = 0; e_cnt[k] = 0;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         model_reset(0);
         model_reset(1);
      end else begin
         model_step(0, 1'b1);
         model_step(1, 1'b0);
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input int k, input string nm, input int act, input int exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL dut%0d %s: got %0d expected %0d at %0t", k, nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_on) begin
         for (int k = 0; k < 2; k++) begin
            chk(k, "bcd_hi", int'(o_hi[k]), e_hi[k]);
            chk(k, "bcd_lo", int'(o_lo[k]), e_lo[k]);
            chk(k, "dec_valid", int'(o_dv[k]), e_dv[k]);
            chk(k, "err", int'(o_err[k]), e_err[k]);
            chk(k, "err_code", int'(o_code[k]), e_code[k]);
            chk(k, "err_cnt", int'(o_cnt[k]), e_cnt[k]);
            chk(k, "state", int'(o_st[k]), m_track[k]);
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic drive(input logic [6:0] hs, input logic [6:0] ls, input logic [1:0] lt,
                        input logic e, input logic t, input logic c);
      @(negedge clk);
      high_seg = hs; low_seg = ls; light = lt; en = e; tick = t; clr_err = c;
      @(negedge clk);
      tick = 1'b0; clr_err = 1'b0;
   endtask

   task automatic tick_val(input int v, input logic [1:0] lt, input logic e, input logic c);
      drive(seg_tab[v / 10], seg_tab[v % 10], lt, e, 1'b1, c);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cur, r, v;
      logic [1:0] lt;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      cmp_on = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk(k, "rst.bcd_hi", int'(o_hi[k]), 0);
         chk(k, "rst.dec_valid", int'(o_dv[k]), 0);
         chk(k, "rst.err", int'(o_err[k]), 0);
         chk(k, "rst.err_cnt", int'(o_cnt[k]), 0);
      end

      // Legal countdown from 20, then reload at light change, then a stuck value.
      tick_val(20, 2'b01, 1'b1, 1'b0);
      chk(0, "t20.hi", int'(o_hi[0]), 2); chk(0, "t20.lo", int'(o_lo[0]), 0);
      tick_val(19, 2'b01, 1'b1, 1'b0);
      chk(0, "t19.hi", int'(o_hi[0]), 1); chk(0, "t19.lo", int'(o_lo[0]), 9);
      tick_val(18, 2'b01, 1'b1, 1'b0);
      chk(0, "t18.lo", int'(o_lo[0]), 8); chk(0, "t18.err", int'(o_err[0]), 0);
      for (int i = 17; i >= 0; i--) tick_val(i, 2'b01, 1'b1, 1'b0);
      tick_val(15, 2'b10, 1'b1, 1'b0);
      chk(0, "reload.err", int'(o_err[0]), 0);
      tick_val(15, 2'b10, 1'b1, 1'b0);
      chk(0, "step.code", int'(o_code[0]), 6); chk(0, "step.cnt", int'(o_cnt[0]), 1);

      // Hold rule: clear, hold 07 with en low, then change while en low.
      tick_val(7, 2'b10, 1'b0, 1'b1);
      chk(0, "clr.err", int'(o_err[0]), 0);
      tick_val(7, 2'b10, 1'b0, 1'b0);
      tick_val(7, 2'b10, 1'b0, 1'b0);
      chk(0, "hold.err", int'(o_err[0]), 0);
      tick_val(6, 2'b10, 1'b0, 1'b0);
      chk(0, "hold.code", int'(o_code[0]), 5);
      chk(1, "nohold.err", int'(o_err[1]), 0);

      // Bad segment forces re-seed.
      drive(seg_tab[0], 7'h00, 2'b10, 1'b1, 1'b1, 1'b0);
      chk(0, "badseg.dv", int'(o_dv[0]), 0); chk(0, "badseg.code", int'(o_code[0]), 1);
      chk(0, "badseg.state", int'(o_st[0]), 0); chk(0, "badseg.lo", int'(o_lo[0]), 15);
      tick_val(5, 2'b10, 1'b1, 1'b0);
      chk(0, "reseed.dv", int'(o_dv[0]), 1); chk(0, "reseed.cnt", int'(o_cnt[0]), 2);
      tick_val(4, 2'b10, 1'b1, 1'b0);
      chk(0, "after.cnt", int'(o_cnt[0]), 2);

      // Light errors.
      tick_val(3, 2'b11, 1'b1, 1'b0);
      chk(0, "badlight.code", int'(o_code[0]), 2);
      tick_val(7, 2'b01, 1'b1, 1'b0);
      tick_val(7, 2'b10, 1'b1, 1'b0);
      chk(0, "lightchg.code", int'(o_code[0]), 3);
      for (int i = 6; i >= 0; i--) tick_val(i, 2'b10, 1'b1, 1'b0);
      tick_val(0, 2'b00, 1'b1, 1'b0);
      chk(0, "reload0.code", int'(o_code[0]), 4); chk(0, "reload0.cnt", int'(o_cnt[0]), 5);

      // Counter saturation, then clear coinciding with a tick.
      repeat (300) tick_val(42, 2'b11, 1'b1, 1'b0);
      chk(0, "sat.cnt", int'(o_cnt[0]), 255); chk(1, "sat.cnt", int'(o_cnt[1]), 255);
      tick_val(42, 2'b01, 1'b1, 1'b1);
      chk(0, "clrtick.err", int'(o_err[0]), 0); chk(0, "clrtick.cnt", int'(o_cnt[0]), 0);
      chk(0, "clrtick.hi", int'(o_hi[0]), 4); chk(0, "clrtick.lo", int'(o_lo[0]), 2);

      // Asynchronous reset between edges.
      tick_val(41, 2'b01, 1'b1, 1'b0);
      tick_val(41, 2'b01, 1'b1, 1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk(0, "arst.hi", int'(o_hi[0]), 0); chk(0, "arst.cnt", int'(o_cnt[0]), 0);
      chk(0, "arst.dv", int'(o_dv[0]), 0);
      @(negedge clk);
      rst = 1'b0;

      // Randomized mix of legal countdown, holds, corruptions and clears.
      cur = 50; lt = 2'b01;
      repeat (600) begin
         r = $urandom_range(0, 99);
         if (r < 8) begin
            drive(7'($urandom), 7'($urandom), 2'($urandom), 1'($urandom), 1'b0,
                  ($urandom_range(0, 3) == 0));
         end else if (r < 60) begin
            if (cur > 0) cur--;
            else begin
               lt = 2'((int'(lt) + 1 + $urandom_range(0, 1)) % 3);
               cur = $urandom_range(1, 99);
            end
            tick_val(cur, lt, 1'b1, 1'b0);
         end else if (r < 75) begin
            tick_val(cur, lt, 1'b0, 1'b0);
         end else if (r < 82) begin
            cur = $urandom_range(0, 99);
            tick_val(cur, lt, 1'b0, 1'b0);
         end else if (r < 88) begin
            v = $urandom_range(0, 99);
            lt = 2'($urandom_range(0, 3));
            tick_val(v, lt, 1'($urandom), 1'b0);
            cur = v;
            if (lt == 2'b11) lt = 2'b00;
         end else if (r < 93) begin
            drive(7'($urandom), seg_tab[$urandom_range(0, 9)], lt, 1'b1, 1'b1, 1'b0);
         end else if (r < 96) begin
            tick_val(cur, lt, 1'b1, 1'b1);
         end else begin
            lt = 2'((int'(lt) + 1) % 3);
            cur = $urandom_range(0, 99);
            tick_val(cur, lt, 1'b1, 1'b0);
         end
      end

      @(negedge clk);
      cmp_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_monitor.md
Name: seg_monitor

Overview:
- Receive-side checker for the countdown display path. It decodes the two 7-segment digit buses and the 2-bit light code back into BCD and light state.
- On every sample strobe it checks that the displayed sequence is a legal countdown: decrement, hold, or reload at light change.
- Flags are sticky and an error counter is kept. Instantiated beside the display top in simulation and on-board self-test; it drives nothing in the functional path.

Parameters:
- ERR_W, 8, width of saturating error counter.
- CHECK_HOLD, 1, when 1 the hold rule (en low => value unchanged) is enforced; when 0 the hold check is skipped.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- tick  input  1  one-clk sample strobe (the 1 Hz enable, synchronous to clk).
- en  input  1  count-enable seen by the counter, sampled with tick.
- high_seg  input  7  tens digit segments, bit6=a ... bit0=g, 1=segment lit.
- low_seg  input  7  units digit segments, same encoding.
- light  input  2  light code; 2'b11 illegal.
- clr_err  input  1  synchronous clear of err, err_code and err_cnt.
- bcd_hi  output  4  decoded tens digit of last sample.
- bcd_lo  output  4  decoded units digit of last sample.
- dec_valid  output  1  last sample decoded to two legal digits.
- err  output  1  sticky error flag.
- err_code  output  3  code of most recent error.
- err_cnt  output  ERR_W  saturating count of erroneous samples.

Behaviour:
- Reset values: bcd_hi=0, bcd_lo=0, dec_valid=0, err=0, err_code=0, err_cnt=0. Internal state = IDLE, prev value=0, prev light=0.
- Decode table (both digits):
  - 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9.
  - Any other pattern is an invalid digit.
- All checks and updates happen only on clk edges with tick=1. With tick=0 all registers hold.
- Outputs are registered: values appear one clk after the tick edge (latency 1).
- FSM states and transitions:
  - IDLE: first tick after reset or clr_err. Decode the sample and capture it as prev. No sequence check. Go to TRACK if the sample is decodable and light!=11, else stay in IDLE and report the error.
  - TRACK: each tick, evaluate the checks below in priority order. Record only the highest-priority failure.
    - 1 BADSEG: either digit is invalid.
    - 2 BADLIGHT: light==11.
    - 3 LIGHTCHG: light differs from prev light but prev value != 00.
    - 4 RELOAD0: light changed but new value == 00.
    - 5 HOLD: en==0, CHECK_HOLD=1, light unchanged, and value != prev.
    - 6 STEP: en==1, light unchanged, and value != prev minus 1 in BCD. Legal steps: 20->19, 10->09, 01->00. An unchanged light at prev 00 is a STEP error.
    - Code 0 means no error.
  - On BADSEG or BADLIGHT, return to IDLE so the next good sample re-seeds prev.
  - Otherwise stay in TRACK and update prev value and prev light with the sample.
- Error side effects: on any error, err<=1, err_code<=code, and err_cnt<=err_cnt+1 saturating at all ones. dec_valid<=0 only for BADSEG, else 1.
- BCD rule: the decrement is computed per digit. Units 0 borrows to 9 and decrements tens. Prev 00 has no legal decrement.
- clr_err: takes effect on any clk edge and forces IDLE.
  - If it coincides with tick, clear wins for the error registers; the sample still updates bcd_hi/bcd_lo/dec_valid and seeds prev as in IDLE.
- rst mid-operation returns immediately to reset values regardless of tick.

Test Plan:
- rst, then ticks with displays 20,19,18 on light=01, en=1 -> bcd 2/0, 1/9, 1/8. err=0, err_cnt=0.
- Sequence 01, 00 on light=01, then light=10 with display 15 -> no error. Next tick at 15 on light=10 with en=1 -> err=1, err_code=6, err_cnt=1.
- en=0 across three ticks at 07 -> no error. Change to 06 while en=0 -> err_code=5. With CHECK_HOLD=0 the same stimulus gives err=0.
- low_seg=7'h00 on one tick -> dec_valid=0, err_code=1, state IDLE. Next tick 05 -> dec_valid=1, no new error. Following tick 04 -> no error.
- light=11 -> err_code=2. Light change at prev 07 -> err_code=3. Light change to 00 from prev 00 -> err_code=4.
- Force 300 erroneous ticks with ERR_W=8 -> err_cnt=255. clr_err on the same edge as a tick -> err=0, err_cnt=0, and bcd reflects the sample.
